pc_unit: RTL and testbench

- Fetch-stage program counter with integrated next-PC selection.
- Holds F-stage PC; redirects on D-stage branch/jump (MIPS delay-slot semantics: targets relative to D-stage PC), exception entry and eret.
- Buffers one redirect that arrives during a stall.
- Flags misaligned or out-of-range fetch addresses for the exception unit.

---
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit.sv | 95 +++++++++
 tb/tb_pc_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Signal bundle between the fetch-stage PC unit and its control/hazard logic.
// The master drives the D-stage and CP0 inputs; the slave is the PC unit itself.
interface pc_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             stall;
   logic             d_valid;
   logic [WIDTH-1:0] d_pc;
   logic [3:0]       npc_op;
   logic [25:0]      imm26;
   logic [15:0]      imm16;
   logic [WIDTH-1:0] ra;
   logic             br_taken;
   logic             exc_req;
   logic             eret_req;
   logic [WIDTH-1:0] epc;
   logic [WIDTH-1:0] f_pc;
   logic [WIDTH-1:0] f_pc4;
   logic             f_adel;
   logic             pend_valid;

   modport master (
      output stall, d_valid, d_pc, npc_op, imm26, imm16, ra, br_taken,
             exc_req, eret_req, epc,
      input  f_pc, f_pc4, f_adel, pend_valid
   );

   modport slave (
      input  stall, d_valid, d_pc, npc_op, imm26, imm16, ra, br_taken,
             exc_req, eret_req, epc,
      output f_pc, f_pc4, f_adel, pend_valid
   );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC selection (MIPS delay-slot branches),
// exception/eret redirects, a one-entry redirect buffer for stalls, and fetch address checking.
module pc_unit #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
   parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [WIDTH-1:0] IM_BASE    = 32'h0000_3000,
   parameter int unsigned      IM_WORDS   = 4096
) (
   input logic    clk,
   input logic    reset,
   pc_unit_if.slave bus
);

   typedef enum logic [3:0] {
      NPC_PC4 = 4'd0,
      NPC_BR  = 4'd1,
      NPC_JAL = 4'd2,
      NPC_JR  = 4'd3
   } npc_op_e;

   localparam logic [WIDTH-1:0] IM_LAST = IM_BASE + WIDTH'(4 * IM_WORDS - 4);

   logic [WIDTH-1:0] f_pc_q, f_pc_d;
   logic             pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

   logic [WIDTH-1:0] f_pc4;
   logic [WIDTH-1:0] br_off;
   logic [WIDTH-1:0] target;
   logic             redir;
   npc_op_e          op;

   assign op     = npc_op_e'(bus.npc_op);
   assign f_pc4  = f_pc_q + WIDTH'(4);
   assign br_off = {{(WIDTH-18){bus.imm16[15]}}, bus.imm16, 2'b00};

   // Targets are relative to the D-stage PC: the delay-slot instruction is already in F.
   always_comb begin
      // NOTE: default first so no path leaves target unassigned and infers a latch.
      target = bus.ra;
      case (op)
         NPC_BR:  target = bus.d_pc + WIDTH'(4) + br_off;
         NPC_JAL: target = {bus.d_pc[WIDTH-1:28], bus.imm26, 2'b00};
         default: target = bus.ra;
      endcase
   end

   assign redir = bus.d_valid & (((op == NPC_BR) & bus.br_taken) |
                                 (op == NPC_JAL) | (op == NPC_JR));

   always_comb begin
      f_pc_d       = f_pc4;
      pend_valid_d = pend_valid_q;
      pend_tgt_d   = pend_tgt_q;
      if (bus.exc_req) begin
         f_pc_d       = HANDLER_PC;
         pend_valid_d = 1'b0;
      end else if (bus.eret_req) begin
         f_pc_d       = bus.epc;
         pend_valid_d = 1'b0;
      end else if (bus.stall) begin
         f_pc_d = f_pc_q;
         // Only the first redirect seen during a stall is kept; later ones belong to wrong-path D.
         if (redir && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = target;
         end
      end else if (pend_valid_q) begin
         f_pc_d       = pend_tgt_q;
         pend_valid_d = 1'b0;
      end else if (redir) begin
         f_pc_d = target;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      if (reset) begin
         f_pc_q       <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_tgt_q   <= '0;
      end else begin
         f_pc_q       <= f_pc_d;
         pend_valid_q <= pend_valid_d;
         pend_tgt_q   <= pend_tgt_d;
      end
   end

   assign bus.f_pc       = f_pc_q;
   assign bus.f_pc4      = f_pc4;
   assign bus.pend_valid = pend_valid_q;
   assign bus.f_adel     = (f_pc_q[1:0] != 2'b00) | (f_pc_q < IM_BASE) | (f_pc_q > IM_LAST);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: each cycle's expected f_pc/pend_valid/f_adel is queued
// when the stimulus is applied and popped for comparison after the clock edge.
module tb_pc_unit;

   typedef struct {
      logic [31:0] pc;
      logic        pend;
      logic        adel;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   exp_t sb_q[$];

   pc_unit_if #(.WIDTH(32)) bus ();

   pc_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Queue the expected post-edge state, clock once, then compare against the popped entry.
   task automatic tick(input string tag, input logic [31:0] pc, input logic pend, input logic adel);
      exp_t e;
      sb_q.push_back('{pc: pc, pend: pend, adel: adel});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check({tag, ".f_pc"},  bus.f_pc,                 e.pc);
      check({tag, ".f_pc4"}, bus.f_pc4,                e.pc + 32'd4);
      check({tag, ".pend"},  {31'd0, bus.pend_valid},  {31'd0, e.pend});
      check({tag, ".adel"},  {31'd0, bus.f_adel},      {31'd0, e.adel});
   endtask

   task automatic d_set(input logic v, input logic [3:0] op, input logic [31:0] pc_d,
                        input logic [31:0] ra);
      bus.d_valid = v;
      bus.npc_op  = op;
      bus.d_pc    = pc_d;
      bus.ra      = ra;
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      bus.stall    = 1'b0;
      bus.d_valid  = 1'b0;
      bus.d_pc     = '0;
      bus.npc_op   = 4'd0;
      bus.imm26    = '0;
      bus.imm16    = '0;
      bus.ra       = '0;
      bus.br_taken = 1'b0;
      bus.exc_req  = 1'b0;
      bus.eret_req = 1'b0;
      bus.epc      = '0;

      tick("reset", 32'h3000, 1'b0, 1'b0);
      reset = 1'b0;
      tick("seq1", 32'h3004, 1'b0, 1'b0);
      tick("seq2", 32'h3008, 1'b0, 1'b0);
      tick("seq3", 32'h300C, 1'b0, 1'b0);

      // Branch back: 3010 + 4 + (-4 << 2) = 3004
      d_set(1'b1, 4'd1, 32'h3010, 32'h0);
      bus.imm16    = 16'hFFFC;
      bus.br_taken = 1'b1;
      tick("br_taken", 32'h3004, 1'b0, 1'b0);
      bus.br_taken = 1'b0;
      tick("br_not", 32'h3008, 1'b0, 1'b0);

      d_set(1'b1, 4'd2, 32'h3020, 32'h0);
      bus.imm26 = 26'h0000C40;
      tick("jal", 32'h3100, 1'b0, 1'b0);

      d_set(1'b1, 4'd3, 32'h3100, 32'h3001);
      tick("jr_misalign", 32'h3001, 1'b0, 1'b1);
      d_set(1'b1, 4'd3, 32'h3100, 32'h2FFC);
      tick("jr_below", 32'h2FFC, 1'b0, 1'b1);
      d_set(1'b1, 4'd0, 32'h3100, 32'h5555);
      tick("pc4_op", 32'h3000, 1'b0, 1'b0);
      d_set(1'b1, 4'd5, 32'h3100, 32'h5555);
      tick("op_other", 32'h3004, 1'b0, 1'b0);
      d_set(1'b0, 4'd3, 32'h3100, 32'h5555);
      tick("bubble_jr", 32'h3008, 1'b0, 1'b0);

      d_set(1'b1, 4'd3, 32'h3100, 32'h6FFC);
      tick("jr_last", 32'h6FFC, 1'b0, 1'b0);
      d_set(1'b0, 4'd0, 32'h3100, 32'h0);
      tick("past_end", 32'h7000, 1'b0, 1'b1);

      // Stall buffering: first redirect kept, second ignored, buffered wins over live.
      bus.stall = 1'b1;
      d_set(1'b1, 4'd3, 32'h3100, 32'h3400);
      tick("stall1", 32'h7000, 1'b1, 1'b1);
      d_set(1'b1, 4'd3, 32'h3100, 32'h3500);
      tick("stall2", 32'h7000, 1'b1, 1'b1);
      bus.stall = 1'b0;
      tick("unstall", 32'h3400, 1'b0, 1'b0);
      d_set(1'b0, 4'd0, 32'h3100, 32'h0);
      tick("after_pend", 32'h3404, 1'b0, 1'b0);

      // Exception and eret together while stalled with a buffered redirect.
      bus.stall = 1'b1;
      d_set(1'b1, 4'd3, 32'h3100, 32'h3600);
      tick("stall_pend", 32'h3404, 1'b1, 1'b0);
      bus.exc_req  = 1'b1;
      bus.eret_req = 1'b1;
      bus.epc      = 32'h3050;
      tick("exc_wins", 32'h4180, 1'b0, 1'b0);
      bus.exc_req = 1'b0;
      bus.stall   = 1'b0;
      d_set(1'b0, 4'd0, 32'h3100, 32'h0);
      tick("eret", 32'h3050, 1'b0, 1'b0);
      bus.eret_req = 1'b0;
      tick("post_eret", 32'h3054, 1'b0, 1'b0);

      // Reset mid-stream with a buffered redirect; the buffered target must not reappear.
      bus.stall = 1'b1;
      d_set(1'b1, 4'd3, 32'h3100, 32'h3700);
      tick("stall_pend2", 32'h3054, 1'b1, 1'b0);
      reset = 1'b1;
      tick("mid_reset", 32'h3000, 1'b0, 1'b0);
      reset     = 1'b0;
      bus.stall = 1'b0;
      d_set(1'b0, 4'd0, 32'h3100, 32'h0);
      tick("post_reset", 32'h3004, 1'b0, 1'b0);

      // Address wraps modulo 2^32.
      d_set(1'b1, 4'd3, 32'h3100, 32'hFFFF_FFFC);
      tick("jr_top", 32'hFFFF_FFFC, 1'b0, 1'b1);
      d_set(1'b0, 4'd0, 32'h3100, 32'h0);
      tick("wrap", 32'h0000_0000, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
